// File: rtl/floo_vc_input_buffer.sv
// floo_vc_input_buffer: per-virtual-channel input buffer at the end of a link.
// Flits arrive on a shared data bus with per-VC valid/ready. Each VC has its
// own FIFO, so backpressure on one VC never blocks the others. A round-robin
// arbiter with a grant lock drives a single valid/ready output.
//
// Handshake: a transfer happens on a port in any cycle where valid and ready
// are both high. Once valid_o is raised it is held, together with data_o and
// vc_id_o, until ready_i accepts it. ready_o is a function of registered
// state only.
//
// Optional build macro FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN: an empty VC with
// valid_i high requests in the same cycle and its flit bypasses the FIFO.
// When the bypassed flit is not accepted it is stored in the FIFO and the
// grant is locked.
module floo_vc_input_buffer #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned IdW  = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumVirtChannels-1:0]      valid_i,
    output logic [NumVirtChannels-1:0]      ready_o,
    input  flit_t                           data_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output flit_t                           data_o,
    output logic [IdW-1:0]                  vc_id_o,
    output logic [NumVirtChannels*CntW-1:0] occupancy_o
);

    flit_t           mem    [NumVirtChannels][Depth];
    logic [PtrW-1:0] rd_ptr [NumVirtChannels];
    logic [PtrW-1:0] wr_ptr [NumVirtChannels];
    logic [CntW-1:0] cnt    [NumVirtChannels];

    logic [IdW-1:0]             rr_ptr;
    logic [IdW-1:0]             lock_gnt;
    logic [IdW-1:0]             arb_gnt;
    logic [IdW-1:0]             gnt;
    logic                       lock;
    logic                       hs;
    logic [NumVirtChannels-1:0] req;
    logic [NumVirtChannels-1:0] push;
    logic [NumVirtChannels-1:0] pop;

    // Pointer advance with wrap from Depth-1 back to 0 (stays 0 when Depth=1).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Per-VC ready, request and occupancy, all from the registered counts.
    always_comb begin
        ready_o     = '0;
        req         = '0;
        occupancy_o = '0;
        for (int v = 0; v < int'(NumVirtChannels); v++) begin
            ready_o[v]                  = (cnt[v] != CntW'(Depth));
            occupancy_o[v*CntW +: CntW] = cnt[v];
`ifdef FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN
            req[v] = (cnt[v] != '0) || valid_i[v];
`else
            req[v] = (cnt[v] != '0);
`endif
        end
    end

    // Round-robin search: first requester at or after rr_ptr, with wrap.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        arb_gnt = '0;
        for (int i = 0; i < int'(NumVirtChannels); i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= int'(NumVirtChannels)) idx = idx - int'(NumVirtChannels);
            if (!found && req[idx]) begin
                found   = 1'b1;
                arb_gnt = IdW'(idx);
            end
        end
    end

    // Output mux; a locked grant overrides the arbiter until the handshake.
    always_comb begin
        gnt     = lock ? lock_gnt : arb_gnt;
        valid_o = |req;
        vc_id_o = gnt;
        hs      = valid_o && ready_i;
`ifdef FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN
        data_o  = (cnt[gnt] == '0) ? data_i : mem[gnt][rd_ptr[gnt]];
`else
        data_o  = mem[gnt][rd_ptr[gnt]];
`endif
    end

    // Push/pop decode; a full FIFO cannot push in the cycle it pops.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int v = 0; v < int'(NumVirtChannels); v++) begin
            pop[v]  = hs && (gnt == IdW'(v)) && (cnt[v] != '0);
`ifdef FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN
            push[v] = valid_i[v] && ready_o[v] &&
                      !(hs && (gnt == IdW'(v)) && (cnt[v] == '0));
`else
            push[v] = valid_i[v] && ready_o[v];
`endif
        end
    end

    // FIFO bookkeeping: pointers and fill count per VC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < int'(NumVirtChannels); v++) begin
                cnt[v]    <= '0;
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
            end
        end else begin
            for (int v = 0; v < int'(NumVirtChannels); v++) begin
                if (push[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                if (push[v] && !pop[v])      cnt[v] <= cnt[v] + CntW'(1);
                else if (pop[v] && !push[v]) cnt[v] <= cnt[v] - CntW'(1);
            end
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        for (int v = 0; v < int'(NumVirtChannels); v++) begin
            if (push[v]) mem[v][wr_ptr[v]] <= data_i;
        end
    end

    // Round-robin pointer and grant lock that keeps a stalled output stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_gnt <= '0;
        end else if (hs) begin
            rr_ptr <= (gnt == IdW'(NumVirtChannels - 1)) ? '0 : gnt + IdW'(1);
            lock   <= 1'b0;
        end else if (valid_o) begin
            lock     <= 1'b1;
            lock_gnt <= gnt;
        end
    end

    // Upstream may raise at most one VC valid per cycle.
    a_onehot_valid : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(valid_i));

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Self-checking bench for floo_vc_input_buffer (2 VCs, depth 2, 8-bit flits).
// A reference model of counts, round-robin pointer and grant lock plus per-VC
// expected-flit queues is advanced on every falling edge and compared with
// the DUT outputs; directed sections add explicit checks on top.
module tb_floo_vc_input_buffer;

    localparam int NVC   = 2;
    localparam int DEPTH = 2;

    typedef logic [7:0] flit_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] valid_i;
    logic [1:0] ready_o;
    flit_t      data_i;
    logic       valid_o;
    logic       ready_i;
    flit_t      data_o;
    logic [0:0] vc_id_o;
    logic [3:0] occupancy_o;

    int n_vec;
    int n_err;

    // Per-VC expected contents and the directed output order.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_q[$];

    int m_cnt[NVC];
    int m_rr;
    bit m_lock;
    int m_lock_gnt;

    floo_vc_input_buffer #(
        .NumVirtChannels(NVC),
        .Depth          (DEPTH),
        .flit_t         (flit_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .vc_id_o    (vc_id_o),
        .occupancy_o(occupancy_o)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic [1:0] v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        ready_i = r;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_i = '0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int model_gnt();
        if (m_lock) return m_lock_gnt;
        for (int i = 0; i < NVC; i++) begin
            int idx;
            idx = (m_rr + i) % NVC;
            if (m_cnt[idx] != 0) return idx;
        end
        return 0;
    endfunction

    // Scoreboard: compare outputs against the model, then advance the model
    // with the inputs that will be sampled at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                m_cnt[0]   = 0;
                m_cnt[1]   = 0;
                m_rr       = 0;
                m_lock     = 0;
                m_lock_gnt = 0;
            end else begin
                bit         any;
                int         eg;
                logic [1:0] exp_rdy;
                logic [7:0] head;
                any     = (m_cnt[0] != 0) || (m_cnt[1] != 0);
                eg      = model_gnt();
                exp_rdy = {m_cnt[1] != DEPTH, m_cnt[0] != DEPTH};
                check_eq("sb_valid_o", 32'(valid_o), 32'(any));
                check_eq("sb_ready_o", 32'(ready_o), 32'(exp_rdy));
                check_eq("sb_occupancy", 32'(occupancy_o), 32'(m_cnt[1] * 4 + m_cnt[0]));
                if (any) begin
                    head = (eg == 1) ? q1[0] : q0[0];
                    check_eq("sb_vc_id", 32'(vc_id_o), 32'(eg));
                    check_eq("sb_data", 32'(data_o), 32'(head));
                end
                if (any && ready_i) begin
                    if (eg == 1) void'(q1.pop_front());
                    else         void'(q0.pop_front());
                    m_cnt[eg]--;
                    m_rr   = (eg + 1) % NVC;
                    m_lock = 0;
                end else if (any) begin
                    m_lock     = 1;
                    m_lock_gnt = eg;
                end
                if (valid_i[0] && exp_rdy[0]) begin q0.push_back(data_i); m_cnt[0]++; end
                if (valid_i[1] && exp_rdy[1]) begin q1.push_back(data_i); m_cnt[1]++; end
            end
        end
    end

    // Stimulus and directed checks
    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        check_eq("rst_ready_o", 32'(ready_o), 32'h3);
        check_eq("rst_valid_o", 32'(valid_o), 32'h0);
        check_eq("rst_occupancy", 32'(occupancy_o), 32'h0);
        check_eq("rst_vc_id", 32'(vc_id_o), 32'h0);

        // Single flit on VC1, visible one cycle later
        drive(2'b10, 8'hA1, 1'b1);
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("t1_valid", 32'(valid_o), 32'h1);
        check_eq("t1_data", 32'(data_o), 32'hA1);
        check_eq("t1_vc", 32'(vc_id_o), 32'h1);
        check_eq("t1_occ", 32'(occupancy_o), 32'h4);
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("t1_occ_after_pop", 32'(occupancy_o), 32'h0);
        check_eq("t1_valid_after_pop", 32'(valid_o), 32'h0);

        // Fill VC0, hold off the third flit, then pop/push on a full FIFO
        drive(2'b01, 8'h10, 1'b0);
        drive(2'b01, 8'h11, 1'b0);
        drive(2'b01, 8'h12, 1'b0);
        @(negedge clk);
        check_eq("t2_full_ready0", 32'(ready_o[0]), 32'h0);
        check_eq("t2_full_occ", 32'(occupancy_o[1:0]), 32'h2);
        check_eq("t2_head", 32'(data_o), 32'h10);
        drive(2'b01, 8'h12, 1'b1);
        @(negedge clk);
        check_eq("t2_pop_full_ready0", 32'(ready_o[0]), 32'h0);
        check_eq("t2_pop_full_occ", 32'(occupancy_o[1:0]), 32'h2);
        drive(2'b01, 8'h12, 1'b1);
        @(negedge clk);
        check_eq("t2_retry_ready0", 32'(ready_o[0]), 32'h1);
        check_eq("t2_retry_occ", 32'(occupancy_o[1:0]), 32'h1);
        check_eq("t2_second", 32'(data_o), 32'h11);
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("t2_pushpop_occ", 32'(occupancy_o[1:0]), 32'h1);
        check_eq("t2_third", 32'(data_o), 32'h12);
        drive(2'b00, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("t2_empty_occ", 32'(occupancy_o), 32'h0);

        // Round-robin alternation from pointer 0
        do_reset();
        drive(2'b01, 8'h20, 1'b0);
        drive(2'b10, 8'h30, 1'b0);
        drive(2'b01, 8'h21, 1'b0);
        drive(2'b10, 8'h31, 1'b0);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h31);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 8'h00, 1'b1);
            @(negedge clk);
            check_eq("t3_rr_order", 32'(data_o), 32'(exp_q.pop_front()));
        end

        // Output stability under backpressure
        drive(2'b01, 8'h40, 1'b0);
        drive(2'b10, 8'h41, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 8'h00, 1'b0);
            @(negedge clk);
            check_eq("t4_hold_valid", 32'(valid_o), 32'h1);
            check_eq("t4_hold_vc", 32'(vc_id_o), 32'h0);
            check_eq("t4_hold_data", 32'(data_o), 32'h40);
        end
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("t4_first_pop_vc", 32'(vc_id_o), 32'h0);
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("t4_second_pop_vc", 32'(vc_id_o), 32'h1);
        drive(2'b00, 8'h00, 1'b0);

        // Random traffic, one VC valid at most per cycle
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            drive((sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b10),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end
        repeat (6) drive(2'b00, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a cycle with data stored
        drive(2'b01, 8'h61, 1'b0);
        drive(2'b10, 8'h62, 1'b0);
        drive(2'b00, 8'h00, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(valid_o), 32'h0);
        check_eq("async_rst_ready", 32'(ready_o), 32'h3);
        check_eq("async_rst_occ", 32'(occupancy_o), 32'h0);
        check_eq("async_rst_vc", 32'(vc_id_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b10, 8'h77, 1'b0);
        drive(2'b00, 8'h00, 1'b1);
        @(negedge clk);
        check_eq("post_rst_data", 32'(data_o), 32'h77);
        drive(2'b00, 8'h00, 1'b1);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/floo_vc_input_buffer.md
Name: floo_vc_input_buffer

Overview:
Per-virtual-channel input buffer that terminates the output of a timing-cut stage on a link. It accepts flits on one shared data bus with per-VC valid/ready and stores them in independent per-VC FIFOs. It then arbitrates round-robin among non-empty VCs onto a single output handshake that feeds the router crossbar.
- Per-VC FIFOs keep backpressure on one VC from blocking the others.

Parameters:
NumVirtChannels, 2, number of virtual channels (>=1)
Depth, 2, entries per VC FIFO (>=1)
flit_t, logic, flit payload type

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
valid_i  input  NumVirtChannels  per-VC input valid
ready_o  output  NumVirtChannels  per-VC input ready
data_i  input  $bits(flit_t)  flit shared by all VCs
valid_o  output  1  output flit valid
ready_i  input  1  downstream ready
data_o  output  $bits(flit_t)  output flit
vc_id_o  output  max(1,$clog2(NumVirtChannels))  VC index of data_o
occupancy_o  output  NumVirtChannels*$clog2(Depth+1)  per-VC fill count, VC0 in LSBs

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all FIFOs empty; occupancy_o=0; RR pointer=0; grant lock cleared; valid_o=0; ready_o all 1; vc_id_o=0; data_o don't-care.
- Push rule:
  - ready_o[v] = (count[v] != Depth).
  - Push into VC v when valid_i[v] && ready_o[v].
  - data_i is written into the tail of FIFO v.
  - At most one valid_i bit may be high per cycle. Violation is a simulation assertion error; RTL behaviour in that case is undefined.
- Latency: storage is registered. A flit pushed at cycle t is eligible for output at t+1 at the earliest.
- A full FIFO does not accept a push in the same cycle as its pop. ready_o depends only on registered count, with no combinational path from ready_i.
- Arbitration:
  - Request vector req[v] = (count[v] != 0).
  - Round-robin grant: the first requesting VC at or after the RR pointer, wrapping modulo NumVirtChannels.
  - valid_o = |req.
  - data_o = head of granted FIFO; vc_id_o = granted index.
- Stability: if valid_o=1 and ready_i=0, the lock is set. While locked, grant, data_o and vc_id_o hold, and valid_o is never retracted. The lock clears on handshake.
- Pop: on valid_o && ready_i, the granted FIFO's head is popped and the RR pointer becomes (grant+1) mod NumVirtChannels.
- Simultaneous push and pop on the same VC:
  - count unchanged, both pointers advance.
  - Allowed only if count<Depth before the cycle (ready_o was high).
- Pointer wrap: read/write pointers wrap from Depth-1 to 0. Depth=1 uses a single entry with no pointer bits.
- count width $clog2(Depth+1); occupancy_o[v] = count[v].
- Reset mid-operation: all stored flits are discarded and outputs return to reset values asynchronously.

Optional Feature:
Macro FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN.
- When defined:
  - A VC whose FIFO is empty and whose valid_i is high counts as requesting in the same cycle.
  - The flit is presented combinationally on data_o (zero latency).
  - On handshake the flit is consumed without being written.
  - If not accepted, it is written into the FIFO, so valid_o, data_o and vc_id_o are stable next cycle (lock set).
- When undefined: 1-cycle minimum latency as above, and no combinational path from data_i or valid_i to outputs.

Test Plan:
- Reset, then push flit 0xA1 on VC1 with ready_i=1 -> ready_o=2'b11 after reset; valid_o=1, data_o=0xA1, vc_id_o=1 on the next cycle; occupancy_o returns to 0 after pop.
- Depth=2, ready_i=0, push 0x10, 0x11, 0x12 on VC0 -> ready_o[0]=0 after the second push, third held off, occupancy VC0=2. Release ready_i -> output order 0x10, 0x11, 0x12.
- Both VCs hold 2 flits each (VC0: 0x20,0x21; VC1: 0x30,0x31), ready_i=1 -> output order 0x20,0x30,0x21,0x31 (alternating RR starting at pointer 0).
- VC0 and VC1 non-empty, ready_i=0 for 3 cycles -> valid_o, data_o and vc_id_o=0 stay constant all 3 cycles; VC0 is popped on the first ready_i=1.
- VC0 full (Depth=2), ready_i=1 while valid_i[0]=1 -> pop occurs, push not accepted that cycle (ready_o[0]=0). Push accepted the next cycle; occupancy goes 2->1->1.
- With FLOO_VC_INPUT_BUFFER_FALL_THROUGH_EN and all FIFOs empty, push 0x55 on VC1 with ready_i=1 -> valid_o=1, data_o=0x55 in the same cycle; occupancy stays 0.
